// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
//
// Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iterations, or in a
// single cycle for divide-by-zero and signed-overflow divides.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   start_i     M-instruction present in EX (sampled in IDLE only)
//   kill_i      synchronous abort, returns to IDLE on the next edge
//   funct3_i    operation select
//   rs1_data_i  operand A (multiplicand / dividend)
//   rs2_data_i  operand B (multiplier / divisor)
//   stall_o     hold request to hazard logic (combinational)
//   done_o      single-cycle result-valid pulse
//   result_o    result word, held until the next accepted start

module muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [4:0]  cnt;
    logic [2:0]  op;
    logic        neg;
    // hi: product high word / partial remainder
    // lo: multiplier (shifts out) + product low word / dividend (shifts out) + quotient
    // opa: multiplicand / divisor magnitude
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] opa;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic        is_div_in;
    logic        a_signed_in, b_signed_in;
    logic        a_neg_in, b_neg_in;
    logic [31:0] a_mag_in, b_mag_in;
    logic        div_by_zero, div_ovf, fast;
    logic        neg_in;
    logic [31:0] fast_result;

    always_comb begin
        is_div_in   = funct3_i[2];
        a_signed_in = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
        b_signed_in = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                      (funct3_i == 3'b110);
        a_neg_in    = a_signed_in && rs1_data_i[31];
        b_neg_in    = b_signed_in && rs2_data_i[31];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
        a_mag_in    = a_neg_in ? (32'd0 - rs1_data_i) : rs1_data_i;
        b_mag_in    = b_neg_in ? (32'd0 - rs2_data_i) : rs2_data_i;

        div_by_zero = is_div_in && (rs2_data_i == 32'd0);
        div_ovf     = is_div_in && !funct3_i[0] &&
                      (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
        fast        = div_by_zero || div_ovf;

        // Remainder follows the dividend sign; products and quotients use the xor
        if (is_div_in && funct3_i[1])
            neg_in = a_neg_in;
        else
            neg_in = a_neg_in ^ b_neg_in;

        if (div_by_zero)
            fast_result = funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
        else
            fast_result = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end

    // ------------------------------------------------------------------
    // One iteration of the datapath, evaluated from the current registers
    // ------------------------------------------------------------------
    logic [32:0] msum;
    logic [32:0] dshift, dtrial;
    logic        dge;
    logic [31:0] hi_n, lo_n;
    logic [63:0] prod, prod_s;
    logic [31:0] quot_s, rem_s;
    logic [31:0] calc_result;

    always_comb begin
        // shift-add: conditionally add multiplicand, then shift {carry,hi,lo} right
        msum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : 33'd0);

        // restoring division: shift in next dividend bit, trial-subtract divisor
        dshift = {hi, lo[31]};
        dtrial = dshift - {1'b0, opa};
        dge    = ~dtrial[32];

        if (op[2]) begin
            hi_n = dge ? dtrial[31:0] : dshift[31:0];
            lo_n = {lo[30:0], dge};
        end else begin
            hi_n = msum[32:1];
            lo_n = {msum[0], lo[31:1]};
        end

        prod   = {hi_n, lo_n};
        prod_s = neg ? (64'd0 - prod) : prod;
        quot_s = neg ? (32'd0 - lo_n) : lo_n;
        rem_s  = neg ? (32'd0 - hi_n) : hi_n;

        case (op)
            3'b000:                 calc_result = prod_s[31:0];
            3'b001, 3'b010, 3'b011: calc_result = prod_s[63:32];
            3'b100, 3'b101:         calc_result = quot_s;
            default:                calc_result = rem_s;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic accept;
    logic last_iter;

    always_comb begin
        state_next = state;
        accept     = (state == IDLE) && start_i && !kill_i;
        last_iter  = (state == CALC) && (cnt == 5'd31);
        stall_o    = accept || (state == CALC);

        if (kill_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i) state_next = fast ? DONE : CALC;
                CALC:    if (cnt == 5'd31) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            done_o   <= 1'b0;
            result_o <= 32'd0;
            op       <= 3'd0;
            neg      <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            opa      <= 32'd0;
        end else begin
            state  <= state_next;
            done_o <= (state_next == DONE);

            if (accept) begin
                op  <= funct3_i;
                neg <= neg_in;
                hi  <= 32'd0;
                lo  <= is_div_in ? a_mag_in : b_mag_in;
                opa <= is_div_in ? b_mag_in : a_mag_in;
                cnt <= 5'd0;
                if (fast)
                    result_o <= fast_result;
            end else if ((state == CALC) && !kill_i) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + 5'd1;
                if (last_iter)
                    result_o <= calc_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .kill_i     (kill),
        .funct3_i   (funct3),
        .rs1_data_i (rs1),
        .rs2_data_i (rs2),
        .stall_o    (stall),
        .done_o     (done),
        .result_o   (result)
    );

    // Reference: RV32M semantics from plain arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p_ss, p_su, p_uu;
        int sa, sb;
        logic ovf;
        p_ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        p_su = {{32{a[31]}}, a} * {32'd0, b};
        p_uu = {32'd0, a} * {32'd0, b};
        sa   = a;
        sb   = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: return p_uu[31:0];
            3'd1: return p_ss[63:32];
            3'd2: return p_su[63:32];
            3'd3: return p_uu[63:32];
            3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return sa / sb;
            3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
            3'd6: if (b == 0) return a; else if (ovf) return 32'd0; else return sa % sb;
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and observe it. lat counts negedges after the accept edge
    // until done_o is seen (-1 on timeout).
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit immediate,
                          output int lat, output logic [31:0] res,
                          output bit stall_ok, output bit held_ok, output bit pulse_ok);
        logic [31:0] prev;
        if (!immediate) @(negedge clk);
        prev   = result;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        kill   = 1'b0;
        #1;
        stall_ok = (stall === 1'b1);
        held_ok  = 1'b1;
        lat      = -1;
        res      = 'x;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (hold && n == 1) begin
                rs1    = $urandom;
                rs2    = $urandom;
                funct3 = 3'($urandom);
            end
            if (done === 1'b1) begin
                lat = n;
                res = result;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (result !== prev) held_ok = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
        pulse_ok = (done === 1'b0) && (stall === 1'b0) && (result === res);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    endtask

    logic [2:0]  dir_f [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] dir_a [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd2, 32'd2,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_e [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          dir_l [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

    task automatic test_directed();
        int lat; logic [31:0] res; bit s_ok, h_ok, p_ok;
        for (int i = 0; i < 12; i++) begin
            run_op(dir_f[i], dir_a[i], dir_b[i], 1'b0, 1'b0, lat, res, s_ok, h_ok, p_ok);
            n_checks++; if (res !== dir_e[i]) begin n_fail++; $display("FAIL directed%0d_result: got %h expected %h", i, res, dir_e[i]); end
            n_checks++; if (lat != dir_l[i]) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, dir_l[i]); end
            n_checks++; if (!s_ok) begin n_fail++; $display("FAIL directed%0d_stall: got wrong stall profile expected high until done", i); end
            n_checks++; if (!p_ok) begin n_fail++; $display("FAIL directed%0d_pulse: got done/stall high or result changed after done expected single pulse", i); end
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] res, a, b, exp; logic [2:0] f; bit s_ok, h_ok, p_ok;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp = ref_result(f, a, b);
            run_op(f, a, b, 1'b0, 1'b0, lat, res, s_ok, h_ok, p_ok);
            n_checks++; if (res !== exp) begin n_fail++; $display("FAIL random%0d_result f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp); end
            n_checks++; if (lat != ref_latency(f, a, b)) begin n_fail++; $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, ref_latency(f, a, b)); end
            n_checks++; if (!h_ok) begin n_fail++; $display("FAIL random%0d_held: got result change during CALC expected held", i); end
        end
    endtask

    task automatic test_hold_start();
        int lat; logic [31:0] res, a, b, exp; bit s_ok, h_ok, p_ok;
        a = $urandom;
        b = $urandom | 32'h0000_0100;
        exp = ref_result(3'd4, a, b);
        run_op(3'd4, a, b, 1'b1, 1'b0, lat, res, s_ok, h_ok, p_ok);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL hold_result: got %h expected %h", res, exp); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL hold_latency: got %0d expected 33", lat); end
        n_checks++; if (!s_ok || !p_ok) begin n_fail++; $display("FAIL hold_single_op: got stall_ok=%0d pulse_ok=%0d expected 1 1", s_ok, p_ok); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic [31:0] res1, res2, a, b; bit s_ok, h_ok, p_ok;
        a = $urandom; b = $urandom;
        run_op(3'd3, a, b, 1'b0, 1'b0, lat1, res1, s_ok, h_ok, p_ok);
        n_checks++; if (res1 !== ref_result(3'd3, a, b)) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", res1, ref_result(3'd3, a, b)); end
        run_op(3'd7, b, a | 32'd1, 1'b0, 1'b1, lat2, res2, s_ok, h_ok, p_ok);
        n_checks++; if (lat2 != 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 33", lat2); end
        n_checks++; if (!h_ok) begin n_fail++; $display("FAIL b2b_result_held: got change during second op expected %h held", res1); end
        n_checks++; if (res2 !== ref_result(3'd7, b, a | 32'd1)) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", res2, ref_result(3'd7, b, a | 32'd1)); end
    endtask

    task automatic test_kill();
        logic [31:0] prev; int done_seen;
        prev = result;
        @(negedge clk);
        funct3 = 3'd3; rs1 = $urandom; rs2 = $urandom; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL kill_stall: got %b expected 0", stall); end
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL kill_no_done: got %0d pulses expected 0", done_seen); end
        n_checks++; if (result !== prev) begin n_fail++; $display("FAIL kill_result: got %h expected %h", result, prev); end
        // kill wins over start in IDLE
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL kill_prio_stall: got %b expected 0", stall); end
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || stall === 1'b1) done_seen++;
        end
        n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL kill_prio_no_op: got %0d busy cycles expected 0", done_seen); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; bit s_ok, h_ok, p_ok;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, lat, res, s_ok, h_ok, p_ok);
        n_checks++; if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL rstmid_pre_result: got %h expected FFFFFFEB", result); end
        @(negedge clk);
        funct3 = 3'd4; rs1 = $urandom; rs2 = 32'd3; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", result); end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, res, s_ok, h_ok, p_ok);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rstmid_fresh_result: got %h expected FFFFFFFE", res); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rstmid_fresh_latency: got %0d expected 33", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_start();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
